// File: rtl/period_meter_pkg.sv
// Shared constants for the period meter: FSM state encoding and default sizing.
package period_meter_pkg;

    // Default result width; must hold DEFAULT_TIMEOUT.
    localparam int unsigned DEFAULT_W       = 27;
    // Default cycle budget between sig rising edges (1 s at 50 MHz).
    localparam int unsigned DEFAULT_TIMEOUT = 50000000;

    // Measurement FSM encoding.
    localparam int unsigned STATE_W    = 1;
    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_MEASURE = 1'b1;

endpackage

// File: rtl/period_meter_sync_rise.sv
// sync_rise: two-flop synchronizer for an asynchronous input followed by a
// registered rising-edge detector.
//   in    : clock
//   rst_n : synchronous active-low reset
//   sig   : asynchronous input
//   rise  : one-cycle pulse, asserted 3 cycles after a 0->1 transition of sig
module sync_rise (
    input  logic in,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;
    logic fill_1;
    logic fill_2;
    logic armed;

    // fill_* marks when sync_2 carries a real sample of sig rather than its
    // reset value; armed then waits for a genuine low so that a sig already
    // high at reset release is not mistaken for a rising edge.
    always_ff @(posedge in) begin
        if (!rst_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            fill_1    <= 1'b0;
            fill_2    <= 1'b0;
            armed     <= 1'b0;
            rise      <= 1'b0;
        end else begin
            sync_1    <= sig;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            fill_1    <= 1'b1;
            fill_2    <= fill_1;
            if (fill_2 && !sync_2) begin
                armed <= 1'b1;
            end
            rise      <= armed && sync_2 && !sync_prev;
        end
    end

endmodule

// File: rtl/period_meter.sv
// period_meter: measures the number of clock cycles between consecutive
// rising edges of an asynchronous signal and offers each result through a
// valid/ready handshake.
//   in      : clock
//   rst_n   : synchronous active-low reset
//   sig     : measured signal (asynchronous)
//   period  : last measured period in clock cycles
//   valid   : period holds an unconsumed result
//   ready   : consumer accepts the result (handshake on valid && ready)
//   overrun : a result was overwritten before it was accepted (sticky)
//   stall   : no rising edge seen within TIMEOUT cycles
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned W       = DEFAULT_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         in,
    input  logic         rst_n,
    input  logic         sig,
    output logic [W-1:0] period,
    output logic         valid,
    input  logic         ready,
    output logic         overrun,
    output logic         stall
);

    localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT - 1);

    logic               rise;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [W-1:0]       cnt;
    logic [W-1:0]       cnt_nxt;
    logic [W-1:0]       period_nxt;
    logic               valid_nxt;
    logic               overrun_nxt;
    logic               stall_nxt;
    logic               new_result;

    sync_rise u_sync_rise (
        .in    (in),
        .rst_n (rst_n),
        .sig   (sig),
        .rise  (rise)
    );

    // State and output registers.
    always_ff @(posedge in) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
            stall   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            period  <= period_nxt;
            valid   <= valid_nxt;
            overrun <= overrun_nxt;
            stall   <= stall_nxt;
        end
    end

    // Next-state, counter and result/handshake logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        period_nxt  = period;
        valid_nxt   = valid;
        overrun_nxt = overrun;
        stall_nxt   = stall;
        new_result  = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = ST_MEASURE;
                    stall_nxt = 1'b0;
                end
            end
            ST_MEASURE: begin
                // A rise on the last allowed cycle still counts as a result.
                if (rise) begin
                    new_result = 1'b1;
                    cnt_nxt    = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                    stall_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // A fresh result wins over a handshake; overrun flags only a result
        // that replaced one the consumer never took.
        if (new_result) begin
            period_nxt  = cnt + W'(1);
            valid_nxt   = 1'b1;
            overrun_nxt = valid && !ready;
        end else if (valid && ready) begin
            valid_nxt   = 1'b0;
            overrun_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter: drives sig waveforms described as gaps between
// rising edges and compares accepted results against a gap-based model.
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned T = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         sig   = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] period;
    logic         valid;
    logic         overrun;
    logic         stall;

    int checks   = 0;
    int failures = 0;

    int got[$];
    int valid_cycles = 0;
    bit ovr_seen     = 1'b0;

    always #5 clk = ~clk;

    period_meter #(.W(W), .TIMEOUT(T)) dut (
        .in      (clk),
        .rst_n   (rst_n),
        .sig     (sig),
        .period  (period),
        .valid   (valid),
        .ready   (ready),
        .overrun (overrun),
        .stall   (stall)
    );

    // Collect accepted results away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) got.push_back(int'(period));
            if (valid) valid_cycles++;
            if (overrun) ovr_seen = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got.delete();
        valid_cycles = 0;
        ovr_seen     = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sig   = 1'b0;
        tick(2);
        rst_n = 1'b1;
        clear_mon();
    endtask

    // sig low for a lead-in, then one rising edge per gap start plus a final
    // rising edge, so consecutive rising edges are gaps[i] cycles apart.
    task automatic drive_wave(input int gaps[$], input int idle);
        int h;
        sig = 1'b0;
        tick(4);
        foreach (gaps[i]) begin
            h = gaps[i] / 2;
            sig = 1'b1;
            tick(h);
            sig = 1'b0;
            tick(gaps[i] - h);
        end
        sig = 1'b1;
        tick(1);
        sig = 1'b0;
        tick(idle);
    endtask

    // Reference: the first rising edge only arms; each later interval within
    // the timeout yields a result equal to the interval, a longer interval
    // yields nothing and the edge that ends it merely re-arms.
    function automatic void model(input int gaps[$], output int exp_q[$]);
        exp_q = {};
        foreach (gaps[i]) begin
            if (gaps[i] <= int'(T)) exp_q.push_back(gaps[i]);
        end
    endfunction

    function automatic bit same_q(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q2s(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        sig   = 1'b1;
        ready = 1'b0;
        tick(3);
        checks++;
        if (period !== '0) begin failures++; $display("FAIL reset_period got=%0h exp=0", period); end
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    endtask

    task automatic test_sig_high_at_release();
        int g[$];
        int e[$];
        ready = 1'b1;
        sig   = 1'b1;
        rst_n = 1'b1;
        clear_mon();
        tick(5);
        sig = 1'b0;
        tick(4);
        g = {6};
        drive_wave(g, 8);
        model(g, e);
        checks++;
        if (!same_q(got, e)) begin
            failures++;
            $display("FAIL high_at_release got=[%s] exp=[%s]", q2s(got), q2s(e));
        end
    endtask

    task automatic test_period10();
        int g[$];
        int e[$];
        apply_reset();
        ready = 1'b1;
        g = {10, 10, 10, 10, 10};
        drive_wave(g, 8);
        model(g, e);
        checks++;
        if (!same_q(got, e)) begin
            failures++;
            $display("FAIL period10 got=[%s] exp=[%s]", q2s(got), q2s(e));
        end
        checks++;
        if (valid_cycles !== 5) begin failures++; $display("FAIL period10_valid_cycles got=%0d exp=5", valid_cycles); end
        checks++;
        if (ovr_seen !== 1'b0) begin failures++; $display("FAIL period10_overrun got=%b exp=0", ovr_seen); end
    endtask

    task automatic test_period2();
        int g[$];
        int e[$];
        apply_reset();
        ready = 1'b1;
        g = {2, 2, 2, 2, 2, 2};
        drive_wave(g, 8);
        model(g, e);
        checks++;
        if (!same_q(got, e)) begin
            failures++;
            $display("FAIL period2 got=[%s] exp=[%s]", q2s(got), q2s(e));
        end
    endtask

    task automatic test_timeout();
        int g[$];
        apply_reset();
        ready = 1'b1;
        sig = 1'b0;
        tick(4);
        sig = 1'b1;
        tick(2);
        sig = 1'b0;
        tick(17);
        // rising edge reaches the FSM 4 edges after sig is driven; stall 16 later
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", stall); end
        tick(1);
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL timeout_stall got=%b exp=1", stall); end
        checks++;
        if (dut.state !== ST_IDLE) begin failures++; $display("FAIL timeout_state got=%b exp=%b", dut.state, ST_IDLE); end
        tick(5);
        checks++;
        if (stall !== 1'b1 || got.size() != 0) begin
            failures++;
            $display("FAIL timeout_hold stall=%b results=%0d exp stall=1 results=0", stall, got.size());
        end
        g = {10};
        drive_wave(g, 6);
        checks++;
        if (got.size() != 1 || got[0] != 10 || stall !== 1'b0) begin
            failures++;
            $display("FAIL timeout_recover got=[%s] stall=%b exp=[10 ] stall=0", q2s(got), stall);
        end
    endtask

    task automatic test_overrun();
        int g[$];
        apply_reset();
        ready = 1'b0;
        g = {8, 12};
        drive_wave(g, 6);
        checks++;
        if (period !== W'(12) || valid !== 1'b1 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set period=%0d valid=%b overrun=%b exp 12/1/1", period, valid, overrun);
        end
        tick(3);
        checks++;
        if (period !== W'(12) || valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_hold period=%0d valid=%b exp 12/1", period, valid);
        end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear valid=%b overrun=%b exp 0/0", valid, overrun);
        end
    endtask

    task automatic test_reset_mid();
        int g[$];
        int e[$];
        apply_reset();
        ready = 1'b0;
        g = {7};
        drive_wave(g, 6);
        checks++;
        if (valid !== 1'b1 || period !== W'(7)) begin
            failures++;
            $display("FAIL resetmid_pre valid=%b period=%0d exp 1/7", valid, period);
        end
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checks++;
        if (period !== '0 || valid !== 1'b0 || overrun !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL resetmid_outputs period=%0d valid=%b overrun=%b stall=%b exp all 0",
                     period, valid, overrun, stall);
        end
        clear_mon();
        ready = 1'b1;
        g = {9};
        drive_wave(g, 6);
        model(g, e);
        checks++;
        if (!same_q(got, e)) begin
            failures++;
            $display("FAIL resetmid_after got=[%s] exp=[%s]", q2s(got), q2s(e));
        end
    endtask

    task automatic test_coincident();
        int g[$];
        int e[$];
        apply_reset();
        ready = 1'b1;
        g = {16};
        drive_wave(g, 6);
        model(g, e);
        checks++;
        if (!same_q(got, e) || stall !== 1'b0) begin
            failures++;
            $display("FAIL coincident got=[%s] stall=%b exp=[%s] stall=0", q2s(got), stall, q2s(e));
        end
        apply_reset();
        g = {17};
        drive_wave(g, 6);
        model(g, e);
        checks++;
        if (!same_q(got, e) || stall !== 1'b0) begin
            failures++;
            $display("FAIL just_over got=[%s] stall=%b exp=[%s] stall=0", q2s(got), stall, q2s(e));
        end
    endtask

    task automatic test_random();
        int g[$];
        int e[$];
        int n;
        for (int r = 0; r < 6; r++) begin
            apply_reset();
            ready = 1'b1;
            g = {};
            n = int'($urandom_range(3, 7));
            for (int k = 0; k < n; k++) g.push_back(int'($urandom_range(2, 20)));
            drive_wave(g, 24);
            model(g, e);
            checks++;
            if (!same_q(got, e)) begin
                failures++;
                $display("FAIL random_%0d gaps=[%s] got=[%s] exp=[%s]", r, q2s(g), q2s(got), q2s(e));
            end
            checks++;
            if (valid_cycles != e.size() || ovr_seen !== 1'b0) begin
                failures++;
                $display("FAIL random_valid_%0d valid_cycles=%0d overrun_seen=%b exp %0d/0",
                         r, valid_cycles, ovr_seen, e.size());
            end
            checks++;
            if (stall !== 1'b1) begin failures++; $display("FAIL random_stall_%0d got=%b exp=1", r, stall); end
        end
    endtask

    initial begin
        test_reset();
        test_sig_high_at_release();
        test_period10();
        test_period2();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_coincident();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
